// File: rtl/bsg_dramsim3_pkg.sv
// Shared DRAMSim3 definitions.
// - bsg_dramsim3_address_mapping_e : how channel, row, rank, bank group,
//   bank and column fields are laid out in a global memory address.
// - bsg_safe_clog2 : clog2 that never returns 0, for index widths.
package bsg_dramsim3_pkg;

  typedef enum logic [1:0] {
    e_ro_ra_bg_ba_co_ch = 2'd0,
    e_ro_ra_bg_ba_ch_co = 2'd1,
    e_ro_ch_ra_ba_bg_co = 2'd2
  } bsg_dramsim3_address_mapping_e;

  function automatic int bsg_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with a valid/yumi dequeue side.
// Ports:
//   clk_i, reset_n_i : clock and synchronous active-low reset
//   v_i, data_i      : enqueue request; accepted unless full, or full and
//                      dequeued in the same cycle
//   full_o           : FIFO holds els_p entries
//   v_o, data_o      : head entry valid / head entry
//   yumi_i           : consumer takes the head this cycle (only when v_o=1)
module bsg_fifo_1r1w_small
  import bsg_dramsim3_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  localparam int ptr_w_lp = bsg_safe_clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wr_r, rd_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o = (cnt_r == cnt_w_lp'(els_p));
  assign v_o    = (cnt_r != '0);
  assign deq    = yumi_i & v_o;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign enq    = v_i & (~full_o | deq);
  assign data_o = mem[rd_r];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_r  <= '0;
      rd_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (enq) wr_r <= ptr_inc(wr_r);
      if (deq) rd_r <= ptr_inc(rd_r);
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_map.sv
// Combinational rebuild of a global memory address from a DRAMSim3
// channel id and the channel-local byte address. Inverse of the
// request-side unmapping: the channel field is re-inserted and, for the
// ro_ch_ra_ba_bg_co layout, the local field order co,ba,bg,ra,ro is
// permuted back to the global order co,bg,ba,ra,ch,ro.
// Ports:
//   ch_i      : channel id
//   ch_addr_i : channel-local byte address
//   addr_o    : global byte address (byte-offset bits are always zero)
module bsg_nonsynth_dramsim3_map
  import bsg_dramsim3_pkg::*;
#(
  parameter int channel_addr_width_p = 20,
  parameter int data_width_p         = 64,
  parameter int num_channels_p       = 2,
  parameter int num_columns_p        = 1024,
  parameter int num_rows_p           = 4,
  parameter int num_ba_p             = 4,
  parameter int num_bg_p             = 4,
  parameter int num_ranks_p          = 2,
  parameter bsg_dramsim3_address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  localparam int bo_lp     = bsg_safe_clog2(data_width_p / 8),
  localparam int lgch_lp   = $clog2(num_channels_p),
  localparam int ch_w_lp   = (lgch_lp < 1) ? 1 : lgch_lp,
  localparam int addr_w_lp = lgch_lp + channel_addr_width_p
) (
  input  logic [ch_w_lp-1:0]              ch_i,
  input  logic [channel_addr_width_p-1:0] ch_addr_i,
  output logic [addr_w_lp-1:0]            addr_o
);

  localparam int cw_lp   = channel_addr_width_p;
  localparam int lgco_lp = $clog2(num_columns_p);
  localparam int lgro_lp = $clog2(num_rows_p);
  localparam int lgba_lp = $clog2(num_ba_p);
  localparam int lgbg_lp = $clog2(num_bg_p);
  localparam int lgra_lp = $clog2(num_ranks_p);

  // Byte-offset bits of the local address carry no information.
  logic unused_bits;
  assign unused_bits = ^{ch_i, ch_addr_i[bo_lp-1:0]};

  assign addr_o[bo_lp-1:0] = '0;

  if (address_mapping_p == e_ro_ra_bg_ba_co_ch) begin : g_co_ch
    if (lgco_lp > cw_lp - bo_lp) begin : g_bad
      $fatal(1, "column field wider than channel address");
    end
    for (genvar i = bo_lp; i < cw_lp; i++) begin : g_hi
      assign addr_o[i+lgch_lp] = ch_addr_i[i];
    end
    for (genvar j = 0; j < lgch_lp; j++) begin : g_ch
      assign addr_o[bo_lp+j] = ch_i[j];
    end
  end else if (address_mapping_p == e_ro_ra_bg_ba_ch_co) begin : g_ch_co
    if (lgco_lp > cw_lp - bo_lp) begin : g_bad
      $fatal(1, "column field wider than channel address");
    end
    for (genvar i = bo_lp; i < bo_lp + lgco_lp; i++) begin : g_co
      assign addr_o[i] = ch_addr_i[i];
    end
    for (genvar j = 0; j < lgch_lp; j++) begin : g_ch
      assign addr_o[bo_lp+lgco_lp+j] = ch_i[j];
    end
    for (genvar i = bo_lp + lgco_lp; i < cw_lp; i++) begin : g_hi
      assign addr_o[i+lgch_lp] = ch_addr_i[i];
    end
  end else if (address_mapping_p == e_ro_ch_ra_ba_bg_co) begin : g_ro_ch
    // Field base positions, LSB up, in the local and global addresses.
    localparam int lco = bo_lp;
    localparam int lba = lco + lgco_lp;
    localparam int lbg = lba + lgba_lp;
    localparam int lra = lbg + lgbg_lp;
    localparam int lro = lra + lgra_lp;
    localparam int gco = bo_lp;
    localparam int gbg = gco + lgco_lp;
    localparam int gba = gbg + lgbg_lp;
    localparam int gra = gba + lgba_lp;
    localparam int gch = gra + lgra_lp;
    localparam int gro = gch + lgch_lp;
    localparam int row_bits = cw_lp - lro;
    if (lgco_lp + lgba_lp + lgbg_lp + lgra_lp + lgro_lp != cw_lp - bo_lp) begin : g_bad
      $fatal(1, "DRAM geometry does not fill the channel address");
    end
    for (genvar i = 0; i < lgco_lp; i++) begin : g_co
      assign addr_o[gco+i] = ch_addr_i[lco+i];
    end
    for (genvar i = 0; i < lgbg_lp; i++) begin : g_bg
      assign addr_o[gbg+i] = ch_addr_i[lbg+i];
    end
    for (genvar i = 0; i < lgba_lp; i++) begin : g_ba
      assign addr_o[gba+i] = ch_addr_i[lba+i];
    end
    for (genvar i = 0; i < lgra_lp; i++) begin : g_ra
      assign addr_o[gra+i] = ch_addr_i[lra+i];
    end
    for (genvar j = 0; j < lgch_lp; j++) begin : g_ch
      assign addr_o[gch+j] = ch_i[j];
    end
    for (genvar i = 0; i < row_bits; i++) begin : g_ro
      assign addr_o[gro+i] = ch_addr_i[lro+i];
    end
  end else begin : g_bad_map
    $fatal(1, "unsupported address_mapping_p");
  end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_resp_map.sv
// Response-return block for the DRAMSim3 model. Each channel's
// non-stallable read responses are buffered in a per-channel FIFO; the
// FIFO heads are arbitrated round-robin onto one valid/yumi stream and
// the granted head's channel-local address is rebuilt into the global
// address.
// Ports:
//   clk_i, reset_n_i : clock and synchronous active-low reset
//   v_i              : per-channel response valid (no backpressure)
//   ch_addr_i        : per-channel local address, channel k at [k*cw +: cw]
//   data_i           : per-channel data, channel k at [k*dw +: dw]
//   v_o, ch_o        : output valid / granted channel
//   addr_o, data_o   : global address / data of the granted response
//   yumi_i           : consumer takes the output (meaningful only with v_o)
//   overflow_o       : sticky; a response arrived at a full FIFO and was lost
module bsg_nonsynth_dramsim3_resp_map
  import bsg_dramsim3_pkg::*;
#(
  parameter int channel_addr_width_p = 20,
  parameter int data_width_p         = 64,
  parameter int num_channels_p       = 2,
  parameter int num_columns_p        = 1024,
  parameter int num_rows_p           = 4,
  parameter int num_ba_p             = 4,
  parameter int num_bg_p             = 4,
  parameter int num_ranks_p          = 2,
  parameter bsg_dramsim3_address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  parameter int fifo_els_p           = 4,
  localparam int lgch_lp   = $clog2(num_channels_p),
  localparam int ch_w_lp   = (lgch_lp < 1) ? 1 : lgch_lp,
  localparam int addr_w_lp = lgch_lp + channel_addr_width_p
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic [num_channels_p-1:0]                  v_i,
  input  logic [num_channels_p*channel_addr_width_p-1:0] ch_addr_i,
  input  logic [num_channels_p*data_width_p-1:0]     data_i,
  output logic                                       v_o,
  output logic [ch_w_lp-1:0]                         ch_o,
  output logic [addr_w_lp-1:0]                       addr_o,
  output logic [data_width_p-1:0]                    data_o,
  input  logic                                       yumi_i,
  output logic                                       overflow_o
);

  localparam int cw_lp = channel_addr_width_p;
  localparam int dw_lp = data_width_p;

  if (fifo_els_p < 2) begin : g_bad_els
    $fatal(1, "fifo_els_p must be at least 2");
  end

  logic [num_channels_p-1:0] fifo_v, fifo_full, fifo_deq;
  logic [cw_lp-1:0]          head_addr [num_channels_p];
  logic [dw_lp-1:0]          head_data [num_channels_p];

  logic [ch_w_lp-1:0] p_r, lock_g_r, rr_g, rr_idx, grant, next_p;
  logic               lock_r, rr_v, take, ovf_now, ovf_r;

  // Per-channel buffering
  for (genvar k = 0; k < num_channels_p; k++) begin : g_ch
    logic [cw_lp+dw_lp-1:0] head;

    bsg_fifo_1r1w_small #(
      .width_p(cw_lp + dw_lp),
      .els_p  (fifo_els_p)
    ) fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (v_i[k]),
      .data_i   ({ch_addr_i[k*cw_lp +: cw_lp], data_i[k*dw_lp +: dw_lp]}),
      .full_o   (fifo_full[k]),
      .v_o      (fifo_v[k]),
      .data_o   (head),
      .yumi_i   (fifo_deq[k])
    );

    assign head_addr[k] = head[cw_lp+dw_lp-1:dw_lp];
    assign head_data[k] = head[dw_lp-1:0];
    assign fifo_deq[k]  = take & (grant == ch_w_lp'(k));
  end

  // Round-robin pick: scanning downward lets the index nearest p win.
  always_comb begin
    rr_v   = 1'b0;
    rr_g   = '0;
    rr_idx = '0;
    for (int i = num_channels_p - 1; i >= 0; i--) begin
      rr_idx = ch_w_lp'((int'(p_r) + i) % num_channels_p);
      if (fifo_v[rr_idx]) begin
        rr_v = 1'b1;
        rr_g = rr_idx;
      end
    end
  end

  // An offered but untaken response stays locked so that a FIFO filling
  // ahead of it in priority cannot swap the output mid-handshake.
  assign grant = lock_r ? lock_g_r : rr_g;
  assign v_o   = lock_r | rr_v;
  assign ch_o  = grant;
  assign take  = yumi_i & v_o;

  assign next_p  = (grant == ch_w_lp'(num_channels_p - 1)) ? '0 : grant + 1'b1;
  assign ovf_now = |(v_i & fifo_full & ~fifo_deq);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      p_r      <= '0;
      lock_r   <= 1'b0;
      lock_g_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (take) p_r <= next_p;
      lock_r   <= v_o & ~yumi_i;
      lock_g_r <= grant;
      if (ovf_now) ovf_r <= 1'b1;
    end
  end

  assign overflow_o = ovf_r;
  assign data_o     = head_data[grant];

  bsg_nonsynth_dramsim3_map #(
    .channel_addr_width_p(channel_addr_width_p),
    .data_width_p        (data_width_p),
    .num_channels_p      (num_channels_p),
    .num_columns_p       (num_columns_p),
    .num_rows_p          (num_rows_p),
    .num_ba_p            (num_ba_p),
    .num_bg_p            (num_bg_p),
    .num_ranks_p         (num_ranks_p),
    .address_mapping_p   (address_mapping_p)
  ) map (
    .ch_i     (grant),
    .ch_addr_i(head_addr[grant]),
    .addr_o   (addr_o)
  );

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_resp_map.sv
module tb_bsg_nonsynth_dramsim3_resp_map;
  import bsg_dramsim3_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [1:0]   v;
  logic [39:0]  ch_addr;
  logic [127:0] data;
  logic         yumi;

  logic         va, vb, ova, ovb;
  logic [0:0]   cha, chb;
  logic [20:0]  addra, addrb, m_addr;
  logic [63:0]  dataa, datab;

  logic [0:0]   m_ch;
  logic [19:0]  m_ch_addr;

  int vectors;
  int miscompares;

  // ch_co mapping, 4-deep FIFOs
  bsg_nonsynth_dramsim3_resp_map #(
    .channel_addr_width_p(20), .data_width_p(64), .num_channels_p(2),
    .num_columns_p(1024), .num_rows_p(4), .num_ba_p(4), .num_bg_p(4),
    .num_ranks_p(2), .address_mapping_p(e_ro_ra_bg_ba_ch_co), .fifo_els_p(4)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ch_addr_i(ch_addr),
    .data_i(data), .v_o(va), .ch_o(cha), .addr_o(addra), .data_o(dataa),
    .yumi_i(yumi), .overflow_o(ova)
  );

  // co_ch mapping, 8-deep FIFOs (deep enough for the dual-push burst)
  bsg_nonsynth_dramsim3_resp_map #(
    .channel_addr_width_p(20), .data_width_p(64), .num_channels_p(2),
    .num_columns_p(1024), .num_rows_p(4), .num_ba_p(4), .num_bg_p(4),
    .num_ranks_p(2), .address_mapping_p(e_ro_ra_bg_ba_co_ch), .fifo_els_p(8)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ch_addr_i(ch_addr),
    .data_i(data), .v_o(vb), .ch_o(chb), .addr_o(addrb), .data_o(datab),
    .yumi_i(yumi), .overflow_o(ovb)
  );

  bsg_nonsynth_dramsim3_map #(
    .channel_addr_width_p(20), .data_width_p(64), .num_channels_p(2),
    .num_columns_p(1024), .num_rows_p(4), .num_ba_p(4), .num_bg_p(4),
    .num_ranks_p(2), .address_mapping_p(e_ro_ch_ra_ba_bg_co)
  ) dut_m (
    .ch_i(m_ch), .ch_addr_i(m_ch_addr), .addr_o(m_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [19:0] a, input logic [63:0] d);
    ch_addr[k*20 +: 20] = a;
    data[k*64 +: 64]    = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    v       = 2'b00;
    ch_addr = '0;
    data    = '0;
    yumi    = 1'b0;
    m_ch      = 1'b1;
    m_ch_addr = 20'hECAA8;

    step();
    step();
    chk("rst_va", 64'(va), 64'd0);
    chk("rst_ova", 64'(ova), 64'd0);
    chk("rst_vb", 64'(vb), 64'd0);
    rst_n = 1'b1;

    // single response on ch1
    v = 2'b10;
    set_ch(1, 20'h12348, 64'hA5);
    step();
    v = 2'b00;
    chk("t1_v", 64'(va), 64'd1);
    chk("t1_ch", 64'(cha), 64'd1);
    chk("t1_addr_ch_co", 64'(addra), 64'h26348);
    chk("t1_data", dataa, 64'hA5);
    chk("t1_addr_co_ch", 64'(addrb), 64'h24698);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("t1_empty", 64'(va), 64'd0);

    // both channels push for 8 cycles with yumi held high
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        v = 2'b11;
        set_ch(0, 20'(c * 8), 64'(32'h100 + c));
        set_ch(1, 20'(32'h800 + c * 8), 64'(32'h200 + c));
      end else begin
        v = 2'b00;
      end
      yumi = 1'b1;
      step();
      chk("alt_v", 64'(vb), 64'd1);
      chk("alt_ch", 64'(chb), 64'(c % 2));
      chk("alt_data", datab, 64'(((c % 2) != 0 ? 32'h200 : 32'h100) + c / 2));
    end
    v = 2'b00;
    step();
    yumi = 1'b0;
    chk("alt_drained", 64'(vb), 64'd0);
    chk("alt_no_ovf", 64'(ovb), 64'd0);

    // overflow after 5 pushes into a 4-deep FIFO
    do_reset();
    chk("rst2_v", 64'(va), 64'd0);
    chk("rst2_ovf", 64'(ova), 64'd0);
    for (int i = 0; i < 5; i++) begin
      v = 2'b01;
      set_ch(0, 20'(i * 8), 64'(32'h10 + i));
      step();
      chk("ovf_head", dataa, 64'h10);
      if (i == 3) chk("ovf_not_yet", 64'(ova), 64'd0);
    end
    v = 2'b00;
    chk("ovf_set", 64'(ova), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_v", 64'(va), 64'd1);
      chk("ovf_drain_data", dataa, 64'(32'h10 + i));
      yumi = 1'b1;
      step();
      yumi = 1'b0;
    end
    chk("ovf_only4", 64'(va), 64'd0);
    chk("ovf_sticky", 64'(ova), 64'd1);

    // output held while waiting even when higher-priority FIFO fills
    do_reset();
    v = 2'b10;
    set_ch(1, 20'h0, 64'h77);
    step();
    v = 2'b01;
    set_ch(0, 20'h0, 64'h66);
    step();
    v = 2'b00;
    chk("hold_ch", 64'(cha), 64'd1);
    chk("hold_data", dataa, 64'h77);
    step();
    chk("hold_ch2", 64'(cha), 64'd1);
    yumi = 1'b1;
    step();
    chk("hold_next_ch", 64'(cha), 64'd0);
    chk("hold_next_data", dataa, 64'h66);
    step();
    yumi = 1'b0;
    chk("hold_empty", 64'(va), 64'd0);

    // full FIFO with simultaneous push and yumi
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 2'b01;
      set_ch(0, 20'h0, 64'(32'h20 + i));
      step();
    end
    v = 2'b00;
    chk("full_no_ovf", 64'(ova), 64'd0);
    v = 2'b01;
    set_ch(0, 20'h0, 64'h24);
    yumi = 1'b1;
    step();
    v = 2'b00;
    chk("full_pushpop_ovf", 64'(ova), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("full_drain_v", 64'(va), 64'd1);
      chk("full_drain_data", dataa, 64'(32'h20 + i));
      step();
    end
    yumi = 1'b0;
    chk("full_occ4", 64'(va), 64'd0);
    chk("full_end_ovf", 64'(ova), 64'd0);

    // reset with 3 entries queued, then a same-cycle tie
    for (int i = 0; i < 3; i++) begin
      v = 2'b01;
      set_ch(0, 20'h0, 64'(32'h30 + i));
      step();
    end
    chk("q3_v", 64'(va), 64'd1);
    rst_n = 1'b0;
    v = 2'b11;
    step();
    chk("rst3_va", 64'(va), 64'd0);
    chk("rst3_ova", 64'(ova), 64'd0);
    chk("rst3_vb", 64'(vb), 64'd0);
    rst_n = 1'b1;
    v = 2'b11;
    set_ch(0, 20'h12348, 64'h40);
    set_ch(1, 20'h12348, 64'h41);
    step();
    v = 2'b00;
    chk("tie_ch", 64'(cha), 64'd0);
    chk("tie_data", dataa, 64'h40);
    chk("tie_addr_ch_co", 64'(addra), 64'h24348);
    chk("tie_addr_co_ch", 64'(addrb), 64'h24690);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("tie_second_ch", 64'(cha), 64'd1);
    chk("tie_second_data", dataa, 64'h41);

    // field-permuting mapping on the standalone map
    chk("map_ro_ch", 64'(m_addr), 64'h1F2AA8);
    m_ch = 1'b0;
    #1;
    chk("map_ro_ch0", 64'(m_addr), 64'h1B2AA8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
